// File: rtl/ahb_slave_mux_pkg.sv
// Shared definitions for the AHB-Lite slave mux: transfer-type encodings,
// FSM state codes and the page size of one slave window.
package ahb_slave_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Each slave owns a 4 KB window.
    localparam int unsigned AHB_PAGE_BITS = 12;
    localparam int unsigned AHB_PAGE_W    = 32 - AHB_PAGE_BITS;

    typedef enum logic [1:0] {
        MuxIdle = 2'd0,
        MuxSlv  = 2'd1,
        MuxErr1 = 2'd2,
        MuxErr2 = 2'd3
    } mux_state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational AHB address decoder.
// Maps the page number HADDR[31:12] onto NSLV consecutive 4 KB windows
// starting at BASE_PAGE.
//   page_i  : HADDR[31:12] of the current address phase
//   valid_i : a real transfer is being presented (HREADY & NONSEQ/SEQ)
//   hit_o   : valid transfer that lands in a mapped window
//   idx_o   : window index (low 3 bits of the page offset)
//   sel_o   : one-hot slave select, all-zero unless hit_o
module ahb_addr_decode
    import ahb_slave_mux_pkg::*;
#(
    parameter int unsigned           NSLV      = 4,
    parameter logic [AHB_PAGE_W-1:0] BASE_PAGE = 20'h40000
) (
    input  logic [AHB_PAGE_W-1:0] page_i,
    input  logic                  valid_i,
    output logic                  hit_o,
    output logic [2:0]            idx_o,
    output logic [NSLV-1:0]       sel_o
);

    logic [AHB_PAGE_W-1:0] offset;

    // Pages below BASE_PAGE wrap to a huge offset and therefore miss.
    assign offset = page_i - BASE_PAGE;
    assign hit_o  = valid_i && (offset < AHB_PAGE_W'(NSLV));
    assign idx_o  = offset[2:0];

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (hit_o && (idx_o == 3'(i))) begin
                sel_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite address decoder and response multiplexer between one master and
// NSLV peripheral slaves. Unmapped accesses are answered by an internal
// default slave with the two-cycle ERROR response.
// Optional feature macro: AHB_MUX_TIMEOUT_EN -- aborts a data phase with
// ERROR after TO_CYCLES wait states.
// Ports:
//   HCLK_I, HRESET_N_I       : clock, async active-low reset
//   HADDR_I/HTRANS_I/HWRITE_I: master address phase
//   HSEL_O, HADDR_O          : per-slave select and forwarded page offset
//   HREADY_O/HRESP_O/HRDATA_O: muxed response to master (HREADY_O also to slaves)
//   SLV_RDATA_I/READY_I/RESP_I: per-slave responses, slave i at slice i
module ahb_slave_mux
    import ahb_slave_mux_pkg::*;
#(
    parameter int unsigned           NSLV      = 4,
    parameter logic [AHB_PAGE_W-1:0] BASE_PAGE = 20'h40000,
    parameter int unsigned           TO_CYCLES = 255
) (
    input  logic                   HCLK_I,
    input  logic                   HRESET_N_I,
    input  logic [31:0]            HADDR_I,
    input  logic [1:0]             HTRANS_I,
    input  logic                   HWRITE_I,
    output logic [NSLV-1:0]        HSEL_O,
    output logic [11:0]            HADDR_O,
    output logic                   HREADY_O,
    output logic                   HRESP_O,
    output logic [31:0]            HRDATA_O,
    input  logic [32*NSLV-1:0]     SLV_RDATA_I,
    input  logic [NSLV-1:0]        SLV_READY_I,
    input  logic [NSLV-1:0]        SLV_RESP_I
);

    mux_state_e      state_q, state_d;
    logic [NSLV-1:0] sel_q;
    logic            valid, hit, miss;
    logic [2:0]      dec_idx;
    logic            slv_ready, slv_resp;
    logic [31:0]     slv_rdata;
    logic            timeout;
    mux_state_e      decode_next;

    // Reset gates valid so HSEL_O stays low while reset is held.
    assign valid   = HRESET_N_I & HREADY_O & HTRANS_I[1];
    assign miss    = valid & ~hit;
    assign HADDR_O = HADDR_I[AHB_PAGE_BITS-1:0];

    ahb_addr_decode #(
        .NSLV      (NSLV),
        .BASE_PAGE (BASE_PAGE)
    ) u_decode (
        .page_i  (HADDR_I[31:AHB_PAGE_BITS]),
        .valid_i (valid),
        .hit_o   (hit),
        .idx_o   (dec_idx),
        .sel_o   (HSEL_O)
    );

    // Response of the data-phase owner (sel_q is one-hot or zero).
    always_comb begin
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (sel_q[i]) begin
                slv_ready = slv_ready | SLV_READY_I[i];
                slv_resp  = slv_resp  | SLV_RESP_I[i];
                slv_rdata = slv_rdata | SLV_RDATA_I[32*i +: 32];
            end
        end
    end

    always_comb begin
        HREADY_O = 1'b1;
        HRESP_O  = 1'b0;
        HRDATA_O = '0;
        unique case (state_q)
            MuxIdle: ;
            MuxSlv: begin
                HREADY_O = slv_ready;
                HRESP_O  = slv_resp;
                HRDATA_O = slv_rdata;
            end
            MuxErr1: begin
                HREADY_O = 1'b0;
                HRESP_O  = 1'b1;
            end
            MuxErr2: HRESP_O = 1'b1;
            default: ;
        endcase
    end

    assign decode_next = hit ? MuxSlv : (miss ? MuxErr1 : MuxIdle);

`ifdef AHB_MUX_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (HREADY_O) begin
            // A completing cycle starts a fresh data phase.
            cnt_d = '0;
        end else if (state_q == MuxSlv) begin
            cnt_d   = cnt_q + 8'd1;
            timeout = (cnt_d == 8'(TO_CYCLES));
        end
    end

    always_ff @(posedge HCLK_I or negedge HRESET_N_I) begin
        if (!HRESET_N_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{HWRITE_I, dec_idx};
`else
    assign timeout = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{HWRITE_I, dec_idx, 32'(TO_CYCLES)};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MuxIdle, MuxErr2: state_d = decode_next;
            MuxSlv: begin
                if (timeout) begin
                    state_d = MuxErr1;
                end else if (slv_ready) begin
                    state_d = decode_next;
                end
            end
            MuxErr1: state_d = MuxErr2;
            default: state_d = MuxIdle;
        endcase
    end

    always_ff @(posedge HCLK_I or negedge HRESET_N_I) begin
        if (!HRESET_N_I) begin
            state_q <= MuxIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (HREADY_O) begin
                sel_q <= HSEL_O;
            end else if (timeout) begin
                // Drop the hung slave so its late READY is ignored.
                sel_q <= '0;
            end
        end
    end

endmodule
